// File: rtl/ping_period_monitor_if.sv
// Ping/status bundle between a ping source (master) and the period monitor (slave).
// The master drives ping/err_clr; the slave returns lock, sticky errors and the ping count.
interface ping_period_monitor_if #(
  parameter int CNT_W = 16
);
  logic             ping;
  logic             err_clr;
  logic             locked;
  logic             err_early;
  logic             err_missed;
  logic             err_pulse;
  logic [CNT_W-1:0] ping_cnt;

  modport master (
    output ping, err_clr,
    input  locked, err_early, err_missed, err_pulse, ping_cnt
  );

  modport slave (
    input  ping, err_clr,
    output locked, err_early, err_missed, err_pulse, ping_cnt
  );
endinterface

// File: rtl/ping_period_monitor.sv
// Checks that ping recurs every 2^WIDTH cycles; PING_PERIOD_MONITOR_FIRST_CHECK_EN starts in TRACK.
// All outputs registered (1-cycle latency); ping is sampled every edge, no backpressure.
module ping_period_monitor #(
  parameter int WIDTH    = 32,
  parameter int LOCK_CNT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ping_period_monitor_if.slave mon
);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [7:0]       LOCK = 8'(LOCK_CNT);

`ifdef PING_PERIOD_MONITOR_FIRST_CHECK_EN
  localparam state_e RST_STATE = TRACK;
`else
  localparam state_e RST_STATE = HUNT;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [7:0]       good_run_q, good_run_d;
  logic             locked_q, locked_d;
  logic             err_early_q, err_early_d;
  logic             err_missed_q, err_missed_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] ping_cnt_q, ping_cnt_d;
  logic             early_ev;
  logic             missed_ev;
  logic             at_max;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q + WIDTH'(1);
    good_run_d = good_run_q;
    early_ev   = 1'b0;
    missed_ev  = 1'b0;
    at_max     = (phase_q == MAX);

    case (state_q)
      HUNT: begin
        if (mon.ping) begin
          phase_d    = '0;
          state_d    = TRACK;
          good_run_d = 8'd0;
        end
      end
      TRACK: begin
        if (mon.ping && at_max) begin
          if (good_run_q < LOCK) good_run_d = good_run_q + 8'd1;
        end else if (mon.ping) begin
          // Early ping: resync phase on it rather than dropping lockstep.
          early_ev   = 1'b1;
          phase_d    = '0;
          good_run_d = 8'd0;
        end else if (at_max) begin
          missed_ev  = 1'b1;
          state_d    = HUNT;
          good_run_d = 8'd0;
        end
      end
      default: state_d = RST_STATE;
    endcase

    locked_d     = (good_run_d == LOCK);
    ping_cnt_d   = (mon.ping && (ping_cnt_q != '1)) ? ping_cnt_q + CNT_W'(1) : ping_cnt_q;
    // A new error event outranks err_clr for its own flag only.
    err_early_d  = early_ev  | (err_early_q  & ~mon.err_clr);
    err_missed_d = missed_ev | (err_missed_q & ~mon.err_clr);
    err_pulse_d  = early_ev | missed_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_STATE;
      phase_q      <= '0;
      good_run_q   <= 8'd0;
      locked_q     <= 1'b0;
      err_early_q  <= 1'b0;
      err_missed_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      ping_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      good_run_q   <= good_run_d;
      locked_q     <= locked_d;
      err_early_q  <= err_early_d;
      err_missed_q <= err_missed_d;
      err_pulse_q  <= err_pulse_d;
      ping_cnt_q   <= ping_cnt_d;
    end
  end

  assign mon.locked     = locked_q;
  assign mon.err_early  = err_early_q;
  assign mon.err_missed = err_missed_q;
  assign mon.err_pulse  = err_pulse_q;
  assign mon.ping_cnt   = ping_cnt_q;

endmodule
